// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel-tick enable and a sync/blank pipeline matched
// to the pixel source latency. Define VGA_TEST_PATTERN_EN to add the i_pattern colour-bar input.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_FP        = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned V_FP        = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BP        = 33,
   parameter int unsigned HSYNC_POL   = 0,
   parameter int unsigned VSYNC_POL   = 0,
   parameter int unsigned CNT_W       = 11,
   parameter int unsigned COLOR_W     = 4,
   parameter int unsigned PIX_LATENCY = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_en,
   input  logic [COLOR_W-1:0] i_red,
   input  logic [COLOR_W-1:0] i_green,
   input  logic [COLOR_W-1:0] i_blue,
`ifdef VGA_TEST_PATTERN_EN
   input  logic               i_pattern,
`endif
   output logic [CNT_W-1:0]   o_x,
   output logic [CNT_W-1:0]   o_y,
   output logic               o_req,
   output logic               o_frame_start,
   output logic               o_hsync,
   output logic               o_vsync,
   output logic               o_de,
   output logic [COLOR_W-1:0] o_red,
   output logic [COLOR_W-1:0] o_green,
   output logic [COLOR_W-1:0] o_blue
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_START  = CNT_W'(H_SYNC + H_BP);
   localparam logic [CNT_W-1:0] H_END    = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [CNT_W-1:0] V_START  = CNT_W'(V_SYNC + V_BP);
   localparam logic [CNT_W-1:0] V_END    = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_SYNC);

   localparam logic HS_ACT = 1'(HSYNC_POL);
   localparam logic VS_ACT = 1'(VSYNC_POL);

   // Pipeline word: {bar[2:0] (pattern builds only), de, vsync, hsync}, syncs kept active-high
`ifdef VGA_TEST_PATTERN_EN
   localparam int unsigned PW = 6;
   localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);
`else
   localparam int unsigned PW = 3;
`endif

   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] vcnt_q, vcnt_d;
   logic [CNT_W-1:0] hx, vy;
   logic             active;
   logic [PW-1:0]    s0_d, s0_q, sd;
   logic             req_q, fs_q;
   logic [CNT_W-1:0] x_q, y_q;
   logic [COLOR_W-1:0] src_r, src_g, src_b;

   always_comb begin
      hcnt_d = hcnt_q + CNT_W'(1);
      vcnt_d = vcnt_q;
      if (hcnt_q == H_LAST) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
      end else if (i_en) begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   assign hx     = hcnt_q - H_START;
   assign vy     = vcnt_q - V_START;
   assign active = (hcnt_q >= H_START) && (hcnt_q < H_END) &&
                   (vcnt_q >= V_START) && (vcnt_q < V_END);

`ifdef VGA_TEST_PATTERN_EN
   logic [CNT_W-1:0] bar_full;
   assign bar_full = hx / BAR_W;
   assign s0_d = {bar_full[2:0], active, vcnt_q < V_SYNC_E, hcnt_q < H_SYNC_E};
`else
   assign s0_d = {active, vcnt_q < V_SYNC_E, hcnt_q < H_SYNC_E};
`endif

   // Stage 0: pixel request and raw timing
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q <= 1'b0;
         fs_q  <= 1'b0;
         x_q   <= '0;
         y_q   <= '0;
         s0_q  <= '0;
      end else if (i_en) begin
         req_q <= active;
         fs_q  <= active && (hcnt_q == H_START) && (vcnt_q == V_START);
         s0_q  <= s0_d;
         if (active) begin
            x_q <= hx;
            y_q <= vy;
         end
      end
   end

   assign o_x           = x_q;
   assign o_y           = y_q;
   assign o_req         = req_q;
   assign o_frame_start = fs_q;

   if (PIX_LATENCY == 0) begin : g_no_delay
      assign sd = s0_q;
   end else begin : g_delay
      logic [PW-1:0] sh_q [PIX_LATENCY];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int unsigned i = 0; i < PIX_LATENCY; i++) sh_q[i] <= '0;
         end else if (i_en) begin
            sh_q[0] <= s0_q;
            for (int unsigned i = 1; i < PIX_LATENCY; i++) sh_q[i] <= sh_q[i-1];
         end
      end

      assign sd = sh_q[PIX_LATENCY-1];
   end

   always_comb begin
      src_r = i_red;
      src_g = i_green;
      src_b = i_blue;
`ifdef VGA_TEST_PATTERN_EN
      if (i_pattern) begin
         src_r = {COLOR_W{sd[5]}};
         src_g = {COLOR_W{sd[4]}};
         src_b = {COLOR_W{sd[3]}};
      end
`endif
   end

   // Output register: polarity applied here, colour forced to 0 outside the active area
   always_ff @(posedge clk) begin
      if (rst) begin
         o_hsync <= ~HS_ACT;
         o_vsync <= ~VS_ACT;
         o_de    <= 1'b0;
         o_red   <= '0;
         o_green <= '0;
         o_blue  <= '0;
      end else if (i_en) begin
         o_hsync <= sd[0] ? HS_ACT : ~HS_ACT;
         o_vsync <= sd[1] ? VS_ACT : ~VS_ACT;
         o_de    <= sd[2];
         o_red   <= sd[2] ? src_r : '0;
         o_green <= sd[2] ? src_g : '0;
         o_blue  <= sd[2] ? src_b : '0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster with random enable, colour and resets.
module tb_vga_timing_gen;

   localparam int HA = 16, HF = 2, HS = 3, HB = 2;
   localparam int VA = 6, VF = 1, VS = 2, VB = 1;
   localparam int HT = HS + HB + HA + HF;
   localparam int VT = VS + VB + VA + VF;
   localparam int FT = HT * VT;
   localparam int HOFF = HS + HB;
   localparam int VOFF = VS + VB;
   localparam int L = 2;
   localparam int NW = 6;
   localparam int CW = 4;
   localparam bit HP = 1'b1;
   localparam bit VP = 1'b0;

   typedef struct {
      logic          req, fs;
      logic [NW-1:0] x, y;
      logic          hs, vs, de;
      logic [CW-1:0] r, g, b;
   } rec_t;

   logic clk = 1'b0;
   logic rst, i_en;
   logic [CW-1:0] i_red, i_green, i_blue;
`ifdef VGA_TEST_PATTERN_EN
   logic i_pattern;
`endif
   logic [NW-1:0] o_x, o_y;
   logic o_req, o_frame_start, o_hsync, o_vsync, o_de;
   logic [CW-1:0] o_red, o_green, o_blue;

   rec_t exp_q[$];
   int checks = 0, errors = 0;
   int k = 0, fs_exp = 0, fs_seen = 0;
   logic [NW-1:0] last_x = '0, last_y = '0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(1), .VSYNC_POL(0), .CNT_W(NW), .COLOR_W(CW), .PIX_LATENCY(L)
   ) dut (
      .clk(clk), .rst(rst), .i_en(i_en),
      .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
`ifdef VGA_TEST_PATTERN_EN
      .i_pattern(i_pattern),
`endif
      .o_x(o_x), .o_y(o_y), .o_req(o_req), .o_frame_start(o_frame_start),
      .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
      .o_red(o_red), .o_green(o_green), .o_blue(o_blue)
   );

   // Raster model: position n counts pixel ticks since reset
   function automatic int hpos(input int n);
      return n % HT;
   endfunction

   function automatic int vpos(input int n);
      return (n / HT) % VT;
   endfunction

   function automatic bit act(input int n);
      return hpos(n) >= HOFF && hpos(n) < HOFF + HA && vpos(n) >= VOFF && vpos(n) < VOFF + VA;
   endfunction

   function automatic rec_t reset_rec();
      rec_t e;
      e.req = 1'b0; e.fs = 1'b0; e.x = '0; e.y = '0;
      e.hs = ~HP; e.vs = ~VP; e.de = 1'b0;
      e.r = '0; e.g = '0; e.b = '0;
      return e;
   endfunction

   task automatic check(input string name, input rec_t e);
      checks++;
      if (o_req !== e.req || o_frame_start !== e.fs || o_x !== e.x || o_y !== e.y ||
          o_hsync !== e.hs || o_vsync !== e.vs || o_de !== e.de ||
          o_red !== e.r || o_green !== e.g || o_blue !== e.b) begin
         errors++;
         $display("FAIL %s t=%0t got req=%b fs=%b x=%0d y=%0d hs=%b vs=%b de=%b rgb=%h%h%h exp req=%b fs=%b x=%0d y=%0d hs=%b vs=%b de=%b rgb=%h%h%h",
                  name, $time, o_req, o_frame_start, o_x, o_y, o_hsync, o_vsync, o_de,
                  o_red, o_green, o_blue, e.req, e.fs, e.x, e.y, e.hs, e.vs, e.de,
                  e.r, e.g, e.b);
      end
   endtask

   // One clock of stimulus; the expectation for an enabled tick is pushed with it
   task automatic drive(input bit r, input bit e);
      rec_t x;
      int q;
      @(negedge clk);
      rst     = r;
      i_en    = e;
      i_red   = CW'($urandom);
      i_green = CW'($urandom);
      i_blue  = CW'($urandom);
`ifdef VGA_TEST_PATTERN_EN
      i_pattern = 1'($urandom_range(0, 1));
`endif
      if (r) begin
         k = 0; last_x = '0; last_y = '0;
      end else if (e) begin
         q = k - 1 - L;
         x.req = act(k);
         x.fs  = act(k) && hpos(k) == HOFF && vpos(k) == VOFF;
         if (x.fs) fs_exp++;
         if (act(k)) begin
            last_x = NW'(hpos(k) - HOFF);
            last_y = NW'(vpos(k) - VOFF);
         end
         x.x = last_x; x.y = last_y;
         if (q < 0) begin
            x.hs = ~HP; x.vs = ~VP; x.de = 1'b0;
            x.r = '0; x.g = '0; x.b = '0;
         end else begin
            x.hs = (hpos(q) < HS) ? HP : ~HP;
            x.vs = (vpos(q) < VS) ? VP : ~VP;
            x.de = act(q);
            x.r = '0; x.g = '0; x.b = '0;
            if (x.de) begin
               x.r = i_red; x.g = i_green; x.b = i_blue;
`ifdef VGA_TEST_PATTERN_EN
               if (i_pattern) begin
                  int bar;
                  bar = (hpos(q) - HOFF) / (HA / 8);
                  x.r = ((bar >> 2) & 1) != 0 ? '1 : '0;
                  x.g = ((bar >> 1) & 1) != 0 ? '1 : '0;
                  x.b = (bar & 1) != 0 ? '1 : '0;
               end
`endif
            end
         end
         exp_q.push_back(x);
         k++;
      end
   endtask

   // Monitor: every enabled tick presents a new output set to compare against the queue
   initial begin
      rec_t last;
      logic rs, en;
      last = reset_rec();
      forever begin
         @(posedge clk);
         rs = rst;
         en = i_en;
         #1;
         if (rs) begin
            last = reset_rec();
            check("reset", last);
         end else if (en) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL underflow t=%0t got enabled tick exp queued record", $time);
            end else begin
               last = exp_q.pop_front();
               check("tick", last);
               if (o_frame_start) fs_seen++;
            end
         end else begin
            check("hold", last);
         end
      end
   end

   initial begin
      rst = 1'b1; i_en = 1'b0; i_red = '0; i_green = '0; i_blue = '0;
`ifdef VGA_TEST_PATTERN_EN
      i_pattern = 1'b0;
`endif
      repeat (3) drive(1'b1, 1'b0);
      for (int i = 0; i < 700; i++) drive(1'b0, 1'b1);
      for (int i = 0; i < 800; i++) drive(1'b0, 1'($urandom_range(0, 1)));
      // Mid-frame reset at line 5, column 9
      while ((k % FT) != 5 * HT + 9) drive(1'b0, 1'b1);
      drive(1'b1, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 1500; i++)
         drive(1'($urandom_range(0, 999) == 0), $urandom_range(0, 3) != 0);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (fs_seen != fs_exp || exp_q.size() != 0) begin
         errors++;
         $display("FAIL frame_count got %0d starts (%0d left queued) exp %0d starts",
                  fs_seen, exp_q.size(), fs_exp);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
